mmu_tlb: RTL and testbench
==========================

Name: mmu_tlb

Overview:
- Fully associative translation lookaside buffer for the MMU; 16 KB pages.
- Each entry maps one 32 KB logical region (tag = logical address bits [31:15]) to a 64-bit physical descriptor holding two page frames, plus 28 flag bits.
- Sits between the MMU request buffer and the page-table walker.
  - The MMU looks up every request here.
  - It refills the TLB when a walk completes.
  - It flushes the TLB on a context switch.

Parameters:
- LRU_TIMING, 10, number of clock cycles between aging steps of the per-entry usage counters.
- ENTRY_N, 4, number of entries; power of two, 2..16.

Ports:
- iCLOCK  in  1  system clock, rising edge.
- inRESET  in  1  asynchronous active-low reset.
- iREMOVE  in  1  flush: invalidate all entries.
- iRD_REQ  in  1  lookup request.
- iRD_ADDR  in  32  logical address to look up.
- oRD_VALID  out  1  lookup result valid (one-cycle pulse).
- oRD_HIT  out  1  lookup hit; qualified by oRD_VALID.
- oRD_FLAGS  out  28  flags of the hit entry.
- oRD_PHYS_ADDR  out  64  physical descriptor of the hit entry; [31:0] is the even page, [63:32] is the odd page.
- iWR_REQ  in  1  refill request.
- iWR_ADDR  in  32  logical address whose tag is written.
- iWR_FLAGS  in  28  flags to store.
- iWR_PHYS_ADDR  in  64  descriptor to store.

Behaviour:
- Clocking: single clock iCLOCK; asynchronous active-low reset inRESET.
- Reset:
  - All valid bits = 0; usage counters = 0; aging timer = 0.
  - oRD_VALID = 0, oRD_HIT = 0, oRD_FLAGS = 0, oRD_PHYS_ADDR = 0.
- Lookup:
  - Latency is exactly 1 cycle. iRD_REQ sampled high at edge N gives oRD_VALID = 1 during cycle N+1 only.
  - oRD_VALID = 0 in any cycle not preceded by a request.
  - Hit: some valid entry has tag == iRD_ADDR[31:15].
  - On hit: oRD_HIT = 1, oRD_FLAGS and oRD_PHYS_ADDR come from that entry, and the entry's usage counter increments (4-bit, saturating at 15).
  - On miss: oRD_HIT = 0, oRD_FLAGS = 0, oRD_PHYS_ADDR = 0.
  - Outputs are registered. When oRD_VALID = 0, oRD_HIT = 0 and the data outputs hold their last value.
  - Lookups may be issued back to back, one per cycle.
- Refill (iWR_REQ):
  - Takes effect at the sampling edge; the entry is visible to lookups sampled from the next edge on.
  - Tag = iWR_ADDR[31:15]. If a valid entry already has that tag, it is overwritten in place.
  - Otherwise the target is the lowest-index invalid entry. If none is invalid, the target is the entry with the smallest usage counter, ties going to the lowest index.
  - The written entry becomes valid and its counter is set to 1.
- Aging: a free-running timer counts 0..LRU_TIMING-1. On wrap, every usage counter shifts right by 1. If aging and a hit increment hit the same entry in the same cycle, apply the increment after the shift.
- Flush: iREMOVE clears all valid bits and counters at the edge.
  - A lookup sampled in the same cycle as iREMOVE returns oRD_VALID = 1, oRD_HIT = 0.
- Simultaneous events:
  - iREMOVE together with iWR_REQ: remove wins; no entry is written.
  - Lookup and refill of the same tag in the same cycle: the lookup sees the pre-write state (miss).
  - Reset asserted mid-operation: immediate return to reset state; any in-flight lookup result is dropped.
- Tag compare ignores iRD_ADDR[14:0]. Selection of the even/odd page within the descriptor is the caller's job.

Optional Feature:
- Macro: MMU_TLB_DATA_RESET_EN.
  - Defined: reset also clears every entry's tag, flags and descriptor storage to 0.
  - Undefined: only valid bits, counters, timer and outputs are reset; data arrays are uninitialised after reset.
- Externally visible behaviour is identical in both builds, because invalid entries never hit.

Decomposition:
- Shared package mmu_pkg:
  - Constants: TLB_TAG_W = 17, PAGE_OFFSET_W = 14, TLB_FLAGS_W = 28, TLB_PHYS_W = 64, TLB_LRU_CNT_W = 4.
  - Typedef tlb_entry_t: valid, tag, flags, phys, usage counter.
- Sub-module tlb_victim_select: combinational. Inputs are the valid vector and counters; output is the replacement index (invalid-first, then min-counter, lowest index).

Test Plan:
- Reset, then iRD_REQ with addr 0x0000_8000 -> next cycle oRD_VALID = 1, oRD_HIT = 0, oRD_FLAGS = 0, oRD_PHYS_ADDR = 0.
- Write tag of 0x1234_8000 with flags 0x0ABCDEF and phys 0x0000_4000_0000_8000; then read 0x1234_BFFF -> oRD_HIT = 1, flags 0x0ABCDEF, phys 0x0000_4000_0000_8000. Read 0x1235_0000 -> miss.
- Fill 4 entries; hit entries 0, 1, 3 repeatedly; write a fifth tag -> entry 2 is replaced. The old entry-2 tag misses; the others still hit.
- Assert iREMOVE with iWR_REQ in the same cycle -> all subsequent lookups miss; the written tag also misses.
- Same-cycle lookup and write of tag T -> that lookup misses; a lookup the following cycle hits.
- Issue back-to-back lookups for 3 cycles -> oRD_VALID stays high 3 cycles, delayed by 1, with per-cycle correct hit/miss.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared MMU types: TLB geometry constants, the TLB entry record and the tag extraction helper.
// Pure definitions; no logic, latency or flow control.
package mmu_pkg;

    localparam int TLB_TAG_W     = 17;
    localparam int PAGE_OFFSET_W = 14;
    localparam int TLB_FLAGS_W   = 28;
    localparam int TLB_PHYS_W    = 64;
    localparam int TLB_LRU_CNT_W = 4;

    // One tag covers an even/odd pair of 16 KB pages, hence the extra bit.
    localparam int TLB_TAG_LSB   = PAGE_OFFSET_W + 1;

    typedef logic [TLB_TAG_W-1:0]     tlb_tag_t;
    typedef logic [TLB_LRU_CNT_W-1:0] tlb_cnt_t;

    typedef struct packed {
        logic                   valid;
        tlb_tag_t               tag;
        logic [TLB_FLAGS_W-1:0] flags;
        logic [TLB_PHYS_W-1:0]  phys;
        tlb_cnt_t               cnt;
    } tlb_entry_t;

    function automatic tlb_tag_t tlb_tag_of(input logic [31:0] addr);
        return addr[31:TLB_TAG_LSB];
    endfunction

endpackage

// File: rtl/tlb_victim_select.sv
// Replacement index for a TLB refill: lowest invalid entry, else lowest-index entry with the smallest usage count.
// Purely combinational, zero latency; no flow control.
module tlb_victim_select
    import mmu_pkg::*;
#(
    parameter int ENTRY_N = 4,
    parameter int IDX_W   = 2
)(
    input  logic     [ENTRY_N-1:0] valid_vec,
    input  tlb_cnt_t [ENTRY_N-1:0] cnt_vec,
    output logic     [IDX_W-1:0]   victim_idx
);

    logic     found_inv;
    tlb_cnt_t min_cnt;

    always_comb begin
        found_inv  = 1'b0;
        victim_idx = '0;
        min_cnt    = cnt_vec[0];
        for (int i = 0; i < ENTRY_N; i++) begin
            if (!found_inv && !valid_vec[i]) begin
                found_inv  = 1'b1;
                victim_idx = IDX_W'(i);
            end
        end
        // Strict less-than keeps ties on the lowest index.
        if (!found_inv) begin
            for (int i = 1; i < ENTRY_N; i++) begin
                if (cnt_vec[i] < min_cnt) begin
                    min_cnt    = cnt_vec[i];
                    victim_idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mmu_tlb.sv
// Fully associative TLB, one tag per 32 KB region, LRU-by-aging replacement; lookup latency 1 cycle, one lookup per cycle, never stalls.
// MMU_TLB_DATA_RESET_EN: when defined, reset also clears tag/flags/descriptor storage.
module mmu_tlb
    import mmu_pkg::*;
#(
    parameter int LRU_TIMING = 10,
    parameter int ENTRY_N    = 4
)(
    input  logic                   iCLOCK,
    input  logic                   inRESET,
    input  logic                   iREMOVE,
    input  logic                   iRD_REQ,
    input  logic [31:0]            iRD_ADDR,
    output logic                   oRD_VALID,
    output logic                   oRD_HIT,
    output logic [TLB_FLAGS_W-1:0] oRD_FLAGS,
    output logic [TLB_PHYS_W-1:0]  oRD_PHYS_ADDR,
    input  logic                   iWR_REQ,
    input  logic [31:0]            iWR_ADDR,
    input  logic [TLB_FLAGS_W-1:0] iWR_FLAGS,
    input  logic [TLB_PHYS_W-1:0]  iWR_PHYS_ADDR
);

    localparam int IDX_W = $clog2(ENTRY_N);
    localparam int TMR_W = (LRU_TIMING > 1) ? $clog2(LRU_TIMING) : 1;

    logic     [ENTRY_N-1:0]     valid_q, valid_d;
    tlb_cnt_t [ENTRY_N-1:0]     cnt_q, cnt_d;
    tlb_tag_t                   tag_q   [ENTRY_N];
    tlb_tag_t                   tag_d   [ENTRY_N];
    logic [TLB_FLAGS_W-1:0]     flags_q [ENTRY_N];
    logic [TLB_FLAGS_W-1:0]     flags_d [ENTRY_N];
    logic [TLB_PHYS_W-1:0]      phys_q  [ENTRY_N];
    logic [TLB_PHYS_W-1:0]      phys_d  [ENTRY_N];
    logic [TMR_W-1:0]           timer_q, timer_d;

    logic                   rd_valid_q, rd_valid_d;
    logic                   rd_hit_q, rd_hit_d;
    logic [TLB_FLAGS_W-1:0] rd_flags_q, rd_flags_d;
    logic [TLB_PHYS_W-1:0]  rd_phys_q, rd_phys_d;

    tlb_tag_t            rd_tag, wr_tag;
    logic                rd_match_any, wr_match_any;
    logic [IDX_W-1:0]    rd_idx, wr_idx, victim_idx, wr_tgt;
    logic                wr_en, lru_tick;
    tlb_entry_t          wr_ent;
    logic                unused_addr_bits;

    assign rd_tag           = tlb_tag_of(iRD_ADDR);
    assign wr_tag           = tlb_tag_of(iWR_ADDR);
    assign unused_addr_bits = ^{iRD_ADDR[TLB_TAG_LSB-1:0], iWR_ADDR[TLB_TAG_LSB-1:0]};

    assign wr_ent = '{valid: 1'b1, tag: wr_tag, flags: iWR_FLAGS,
                      phys: iWR_PHYS_ADDR, cnt: tlb_cnt_t'(1)};

    // Refills never create duplicate tags, so at most one entry can match.
    always_comb begin
        rd_match_any = 1'b0;
        rd_idx       = '0;
        wr_match_any = 1'b0;
        wr_idx       = '0;
        for (int i = 0; i < ENTRY_N; i++) begin
            if (!rd_match_any && valid_q[i] && (tag_q[i] == rd_tag)) begin
                rd_match_any = 1'b1;
                rd_idx       = IDX_W'(i);
            end
            if (!wr_match_any && valid_q[i] && (tag_q[i] == wr_tag)) begin
                wr_match_any = 1'b1;
                wr_idx       = IDX_W'(i);
            end
        end
    end

    tlb_victim_select #(
        .ENTRY_N (ENTRY_N),
        .IDX_W   (IDX_W)
    ) u_victim (
        .valid_vec  (valid_q),
        .cnt_vec    (cnt_q),
        .victim_idx (victim_idx)
    );

    assign wr_tgt   = wr_match_any ? wr_idx : victim_idx;
    assign wr_en    = iWR_REQ && !iREMOVE;
    assign lru_tick = (timer_q == TMR_W'(LRU_TIMING - 1));

    always_comb begin
        timer_d = lru_tick ? '0 : timer_q + 1'b1;

        rd_valid_d = iRD_REQ;
        rd_hit_d   = iRD_REQ && rd_match_any && !iREMOVE;
        rd_flags_d = rd_flags_q;
        rd_phys_d  = rd_phys_q;
        if (iRD_REQ) begin
            rd_flags_d = rd_hit_d ? flags_q[rd_idx] : '0;
            rd_phys_d  = rd_hit_d ? phys_q[rd_idx]  : '0;
        end
    end

    // Entry update order: age, then hit increment, then refill, then flush.
    always_comb begin
        for (int i = 0; i < ENTRY_N; i++) begin
            valid_d[i] = valid_q[i];
            cnt_d[i]   = lru_tick ? (cnt_q[i] >> 1) : cnt_q[i];
            tag_d[i]   = tag_q[i];
            flags_d[i] = flags_q[i];
            phys_d[i]  = phys_q[i];

            if (rd_hit_d && (rd_idx == IDX_W'(i)) && (cnt_d[i] != '1)) begin
                cnt_d[i] = cnt_d[i] + 1'b1;
            end

            if (wr_en && (wr_tgt == IDX_W'(i))) begin
                valid_d[i] = wr_ent.valid;
                cnt_d[i]   = wr_ent.cnt;
                tag_d[i]   = wr_ent.tag;
                flags_d[i] = wr_ent.flags;
                phys_d[i]  = wr_ent.phys;
            end

            if (iREMOVE) begin
                valid_d[i] = 1'b0;
                cnt_d[i]   = '0;
            end
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            valid_q    <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_flags_q <= '0;
            rd_phys_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            rd_valid_q <= rd_valid_d;
            rd_hit_q   <= rd_hit_d;
            rd_flags_q <= rd_flags_d;
            rd_phys_q  <= rd_phys_d;
        end
    end

`ifdef MMU_TLB_DATA_RESET_EN
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            for (int i = 0; i < ENTRY_N; i++) begin
                tag_q[i]   <= '0;
                flags_q[i] <= '0;
                phys_q[i]  <= '0;
            end
        end else begin
            tag_q   <= tag_d;
            flags_q <= flags_d;
            phys_q  <= phys_d;
        end
    end
`else
    // Data storage is gated by valid bits, so it needs no reset.
    always_ff @(posedge iCLOCK) begin
        tag_q   <= tag_d;
        flags_q <= flags_d;
        phys_q  <= phys_d;
    end
`endif

    assign oRD_VALID     = rd_valid_q;
    assign oRD_HIT       = rd_hit_q;
    assign oRD_FLAGS     = rd_flags_q;
    assign oRD_PHYS_ADDR = rd_phys_q;

endmodule

// File: tb/tb_mmu_tlb.sv
// Self-checking bench for mmu_tlb: directed scenarios plus random traffic against a behavioural TLB model.
module tb_mmu_tlb;

    localparam int LRU_T = 10;
    localparam int EN    = 4;

    logic        iCLOCK = 1'b0;
    logic        inRESET;
    logic        iREMOVE;
    logic        iRD_REQ;
    logic [31:0] iRD_ADDR;
    logic        oRD_VALID;
    logic        oRD_HIT;
    logic [27:0] oRD_FLAGS;
    logic [63:0] oRD_PHYS_ADDR;
    logic        iWR_REQ;
    logic [31:0] iWR_ADDR;
    logic [27:0] iWR_FLAGS;
    logic [63:0] iWR_PHYS_ADDR;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit          m_valid [EN];
    int          m_tag   [EN];
    logic [27:0] m_flags [EN];
    logic [63:0] m_phys  [EN];
    int          m_cnt   [EN];
    int          m_timer;
    bit          e_valid, e_hit;
    logic [27:0] e_flags;
    logic [63:0] e_phys;

    logic [16:0] pool [6];

    mmu_tlb #(.LRU_TIMING(LRU_T), .ENTRY_N(EN)) dut (
        .iCLOCK        (iCLOCK),
        .inRESET       (inRESET),
        .iREMOVE       (iREMOVE),
        .iRD_REQ       (iRD_REQ),
        .iRD_ADDR      (iRD_ADDR),
        .oRD_VALID     (oRD_VALID),
        .oRD_HIT       (oRD_HIT),
        .oRD_FLAGS     (oRD_FLAGS),
        .oRD_PHYS_ADDR (oRD_PHYS_ADDR),
        .iWR_REQ       (iWR_REQ),
        .iWR_ADDR      (iWR_ADDR),
        .iWR_FLAGS     (iWR_FLAGS),
        .iWR_PHYS_ADDR (iWR_PHYS_ADDR)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < EN; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 0;
        end
        m_timer = 0;
        e_valid = 1'b0;
        e_hit   = 1'b0;
        e_flags = '0;
        e_phys  = '0;
    endtask

    // One rising edge of the TLB as described by its rules.
    task automatic model_step(input bit rd, input logic [31:0] ra, input bit wr,
                              input logic [31:0] wa, input logic [27:0] wf,
                              input logic [63:0] wp, input bit rm);
        int hit_i, tgt, rtag, wtag;
        rtag  = int'(ra >> 15);
        wtag  = int'(wa >> 15);
        hit_i = -1;
        for (int i = 0; i < EN; i++)
            if (m_valid[i] && m_tag[i] == rtag) hit_i = i;
        if (rm || !rd) hit_i = -1;

        e_valid = rd;
        e_hit   = (hit_i >= 0);
        if (rd) begin
            e_flags = (hit_i >= 0) ? m_flags[hit_i] : 28'd0;
            e_phys  = (hit_i >= 0) ? m_phys[hit_i]  : 64'd0;
        end

        tgt = -1;
        if (wr && !rm) begin
            for (int i = 0; i < EN; i++)
                if (m_valid[i] && m_tag[i] == wtag) tgt = i;
            if (tgt < 0)
                for (int i = EN - 1; i >= 0; i--)
                    if (!m_valid[i]) tgt = i;
            if (tgt < 0) begin
                tgt = 0;
                for (int i = 1; i < EN; i++)
                    if (m_cnt[i] < m_cnt[tgt]) tgt = i;
            end
        end

        if (m_timer == LRU_T - 1) begin
            m_timer = 0;
            for (int i = 0; i < EN; i++) m_cnt[i] = m_cnt[i] / 2;
        end else begin
            m_timer++;
        end
        if (hit_i >= 0 && m_cnt[hit_i] < 15) m_cnt[hit_i]++;

        if (tgt >= 0) begin
            m_valid[tgt] = 1'b1;
            m_tag[tgt]   = wtag;
            m_flags[tgt] = wf;
            m_phys[tgt]  = wp;
            m_cnt[tgt]   = 1;
        end
        if (rm)
            for (int i = 0; i < EN; i++) begin
                m_valid[i] = 1'b0;
                m_cnt[i]   = 0;
            end
    endtask

    // Drive one cycle of inputs, advance the model, then check the registered result.
    task automatic cyc(input bit rd, input logic [31:0] ra, input bit wr,
                       input logic [31:0] wa, input logic [27:0] wf,
                       input logic [63:0] wp, input bit rm);
        iRD_REQ = rd; iRD_ADDR = ra;
        iWR_REQ = wr; iWR_ADDR = wa; iWR_FLAGS = wf; iWR_PHYS_ADDR = wp;
        iREMOVE = rm;
        model_step(rd, ra, wr, wa, wf, wp, rm);
        @(negedge iCLOCK);
        chk("rd_valid", 64'(oRD_VALID), 64'(e_valid));
        chk("rd_hit",   64'(oRD_HIT),   64'(e_hit));
        chk("rd_flags", 64'(oRD_FLAGS), 64'(e_flags));
        chk("rd_phys",  oRD_PHYS_ADDR,  e_phys);
    endtask

    task automatic rd_only(input logic [31:0] a);
        cyc(1'b1, a, 1'b0, 32'd0, 28'd0, 64'd0, 1'b0);
    endtask

    task automatic wr_only(input logic [31:0] a, input logic [27:0] f, input logic [63:0] p);
        cyc(1'b0, 32'd0, 1'b1, a, f, p, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 28'd0, 64'd0, 1'b0);
    endtask

    function automatic logic [31:0] region(input int n);
        return 32'h4000_0000 + 32'(n) * 32'h8000;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, wa;
        int k;
        inRESET = 1'b0; iREMOVE = 1'b0; iRD_REQ = 1'b0; iRD_ADDR = '0;
        iWR_REQ = 1'b0; iWR_ADDR = '0; iWR_FLAGS = '0; iWR_PHYS_ADDR = '0;
        for (int i = 0; i < 6; i++) pool[i] = 17'(i * 17'h0a35 + 17'h0101);
        model_reset();

        repeat (3) @(negedge iCLOCK);
        chk("rst_valid", 64'(oRD_VALID), 64'd0);
        chk("rst_hit",   64'(oRD_HIT),   64'd0);
        chk("rst_flags", 64'(oRD_FLAGS), 64'd0);
        chk("rst_phys",  oRD_PHYS_ADDR,  64'd0);
        inRESET = 1'b1;

        // Empty TLB lookup
        rd_only(32'h0000_8000);
        chk("t1_valid", 64'(oRD_VALID), 64'd1);
        chk("t1_hit",   64'(oRD_HIT),   64'd0);
        chk("t1_phys",  oRD_PHYS_ADDR,  64'd0);
        idle();
        chk("t1_idle_valid", 64'(oRD_VALID), 64'd0);

        // Refill then hit anywhere in the 32 KB region
        wr_only(32'h1234_8000, 28'h0ABCDEF, 64'h0000_4000_0000_8000);
        rd_only(32'h1234_BFFF);
        chk("t2_hit",   64'(oRD_HIT),   64'd1);
        chk("t2_flags", 64'(oRD_FLAGS), 64'h0ABCDEF);
        chk("t2_phys",  oRD_PHYS_ADDR,  64'h0000_4000_0000_8000);
        rd_only(32'h1235_0000);
        chk("t2_miss",  64'(oRD_HIT),   64'd0);
        chk("t2_miss_flags", 64'(oRD_FLAGS), 64'd0);

        // Eviction of the least used entry
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 28'd0, 64'd0, 1'b1);
        for (int i = 0; i < 4; i++)
            wr_only(region(i), 28'(32'h100 + i), {32'(i), 32'h1000});
        for (int r = 0; r < 6; r++) begin
            rd_only(region(0));
            rd_only(region(1));
            rd_only(region(3));
        end
        wr_only(region(4), 28'h0000444, 64'h4444_0000_5555_0000);
        rd_only(region(2));
        chk("t3_evicted", 64'(oRD_HIT), 64'd0);
        rd_only(region(4));
        chk("t3_new_hit",  64'(oRD_HIT),  64'd1);
        chk("t3_new_phys", oRD_PHYS_ADDR, 64'h4444_0000_5555_0000);
        rd_only(region(0));
        chk("t3_keep0", 64'(oRD_HIT), 64'd1);
        rd_only(region(3));
        chk("t3_keep3", 64'(oRD_HIT), 64'd1);

        // Flush beats a same-cycle refill
        cyc(1'b1, region(1), 1'b1, region(7), 28'h7, 64'h7, 1'b1);
        chk("t4_same_cycle_hit", 64'(oRD_HIT), 64'd0);
        rd_only(region(1));
        chk("t4_flushed", 64'(oRD_HIT), 64'd0);
        rd_only(region(7));
        chk("t4_not_written", 64'(oRD_HIT), 64'd0);

        // Lookup sees pre-write state
        cyc(1'b1, region(9), 1'b1, region(9), 28'h99, 64'h9999, 1'b0);
        chk("t5_same_cycle", 64'(oRD_HIT), 64'd0);
        rd_only(region(9));
        chk("t5_next_cycle", 64'(oRD_HIT), 64'd1);

        // Back-to-back lookups
        rd_only(region(9));
        rd_only(region(5));
        rd_only(region(9));
        chk("t6_b2b_valid", 64'(oRD_VALID), 64'd1);
        idle();

        // Random traffic over a small tag pool
        for (int n = 0; n < 400; n++) begin
            k  = $urandom_range(0, 5);
            ra = {pool[k], 15'($urandom)};
            k  = $urandom_range(0, 5);
            wa = {pool[k], 15'($urandom)};
            cyc(($urandom_range(0, 9) < 7), ra, ($urandom_range(0, 9) < 3), wa,
                28'($urandom), {$urandom, $urandom}, ($urandom_range(0, 49) == 0));
        end

        // Asynchronous reset with a lookup in flight
        iRD_REQ = 1'b1; iRD_ADDR = {pool[0], 15'd0};
        iWR_REQ = 1'b0; iREMOVE = 1'b0;
        @(posedge iCLOCK);
        #1;
        chk("pre_rst_valid", 64'(oRD_VALID), 64'd1);
        inRESET = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(oRD_VALID), 64'd0);
        chk("mid_rst_hit",   64'(oRD_HIT),   64'd0);
        chk("mid_rst_flags", 64'(oRD_FLAGS), 64'd0);
        chk("mid_rst_phys",  oRD_PHYS_ADDR,  64'd0);
        iRD_REQ = 1'b0;
        @(negedge iCLOCK);
        inRESET = 1'b1;
        model_reset();
        rd_only(region(9));
        chk("post_rst_miss", 64'(oRD_HIT), 64'd0);
        for (int n = 0; n < 100; n++) begin
            k = $urandom_range(0, 5);
            cyc(1'b1, {pool[k], 15'($urandom)}, ($urandom_range(0, 3) == 0),
                {pool[$urandom_range(0, 5)], 15'd0}, 28'($urandom),
                {$urandom, $urandom}, 1'b0);
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
